// File: rtl/hamming_enc_seq.sv
// Sequential Hamming(16,11) encoder: reads NUM_MSG 11-bit messages from a byte memory and writes 16-bit codewords back.
// Define HAMMING_ENC_SEQ_P0_EN for SECDED (overall parity in bit 0); otherwise SEC only with bit 0 tied low.
module hamming_enc_seq #(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  output logic       ack,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned ADR_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);
  localparam logic [ADR_W-1:0] SRC_B    = ADR_W'(SRC_BASE);
  localparam logic [ADR_W-1:0] DST_B    = ADR_W'(DST_BASE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [11:1]      data_q, data_d;
  logic             ack_q, ack_d;
  logic [ADR_W-1:0] addr_q, addr_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [15:0]      cw;
  logic [ADR_W-1:0] src_even, dst_even;

  function automatic logic [15:0] encode(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ d[4] ^ d[3] ^ d[2];
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
`ifdef HAMMING_ENC_SEQ_P0_EN
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
`else
    p0 = 1'b0;
`endif
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  // State transitions and data capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RD_LO;
          idx_d   = '0;
        end
      end
      RD_LO: begin
        data_d[8:1] = mem_rd_data;
        state_d     = RD_HI;
      end
      RD_HI: begin
        data_d[11:9] = mem_rd_data[2:0];
        state_d      = WR_LO;
      end
      WR_LO: state_d = WR_HI;
      WR_HI: begin
        if (idx_q < LAST_IDX) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD_LO;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it
  always_comb begin
    ack_d     = 1'b0;
    addr_d    = '0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    cw        = encode(data_d);
    src_even  = SRC_B + ADR_W'({idx_d, 1'b0});
    dst_even  = DST_B + ADR_W'({idx_d, 1'b0});
    case (state_d)
      RD_LO: addr_d = src_even;
      RD_HI: addr_d = src_even + ADR_W'(1);
      WR_LO: begin
        addr_d    = dst_even;
        wr_en_d   = 1'b1;
        wr_data_d = cw[7:0];
      end
      WR_HI: begin
        addr_d    = dst_even + ADR_W'(1);
        wr_en_d   = 1'b1;
        wr_data_d = cw[15:8];
      end
      DONE:    ack_d = 1'b1;
      default: ack_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign ack         = ack_q;
  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Bench for hamming_enc_seq: a default-size instance against a positional Hamming model, plus a single-message instance for fixed vectors.
module tb_hamming_enc_seq;

  logic       clk;
  logic       reset;
  logic       req, req1;
  logic       ack, ack1;
  logic [7:0] addr, addr1, rd_data, rd_data1, wr_data, wr_data1;
  logic       wr_en, wr_en1;
  logic [7:0] mem  [256];
  logic [7:0] mem1 [256];
  int         n_cmp, n_err;
  int         low_writes, ack_cnt;

  hamming_enc_seq u_dut (
    .clock(clk), .reset(reset), .req(req), .ack(ack), .mem_addr(addr),
    .mem_rd_data(rd_data), .mem_wr_en(wr_en), .mem_wr_data(wr_data)
  );

  hamming_enc_seq #(.NUM_MSG(1)) u_one (
    .clock(clk), .reset(reset), .req(req1), .ack(ack1), .mem_addr(addr1),
    .mem_rd_data(rd_data1), .mem_wr_en(wr_en1), .mem_wr_data(wr_data1)
  );

  assign rd_data  = mem[addr];
  assign rd_data1 = mem1[addr1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
      if (addr < 8'd30) low_writes <= low_writes + 1;
    end
    if (wr_en1) mem1[addr1] <= wr_data1;
    if (ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Classic positional Hamming: data fills non-power-of-two positions, parity p covers positions with bit p set
  function automatic logic [15:0] ref_cw(input logic [7:0] lo, input logic [7:0] hi);
    logic [11:1] d;
    logic [15:0] c;
    int k;
    d = {hi[2:0], lo};
    c = '0;
    k = 1;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      for (int j = 1; j < 16; j++)
        if (((j & p) != 0) && (j != p)) c[p] = c[p] ^ c[j];
    end
`ifdef HAMMING_ENC_SEQ_P0_EN
    c[0] = ^c[15:1];
`endif
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_src();
    for (int a = 0; a < 30; a++) mem[a] = 8'($urandom_range(0, 255));
    for (int a = 30; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic check_outputs(input string tag, input int nmsg);
    for (int i = 0; i < nmsg; i++)
      check(tag, {16'h0, mem[31 + 2*i], mem[30 + 2*i]}, {16'h0, ref_cw(mem[2*i], mem[2*i + 1])});
  endtask

  task automatic run_one(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi);
    int first;
    for (int a = 0; a < 256; a++) mem1[a] = 8'h55;
    mem1[0] = lo;
    mem1[1] = hi;
    first = -1;
    req1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      req1 = 1'b0;
      if (ack1 && first < 0) first = k;
    end
    check({tag, "_ack_cycle"}, first, 5);
    check({tag, "_lo"}, {24'h0, mem1[30]}, {24'h0, exp_lo});
    check({tag, "_hi"}, {24'h0, mem1[31]}, {24'h0, exp_hi});
  endtask

  initial begin
    logic [7:0] snap [10];
    int first, second, diffs;
    logic [7:0] bit0;
    n_cmp = 0; n_err = 0; low_writes = 0; ack_cnt = 0;
    req = 1'b1; req1 = 1'b1; reset = 1'b1;
    for (int a = 0; a < 256; a++) begin mem[a] = 8'h00; mem1[a] = 8'h00; end
    // Reset held with req high: reset must win
    repeat (3) step();
    check("rst_ack", ack, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ack1", ack1, 0);
    req = 1'b0; req1 = 1'b0; reset = 1'b0;
    step();
    check("idle_addr", addr, 0);

`ifdef HAMMING_ENC_SEQ_P0_EN
    bit0 = 8'h01;
`else
    bit0 = 8'h00;
`endif
    run_one("v01_00", 8'h01, 8'h00, 8'h0E | bit0, 8'h00);
    run_one("vff_07", 8'hFF, 8'h07, 8'hFE | bit0, 8'hFF);
    run_one("v00_00", 8'h00, 8'h00, 8'h00, 8'h00);
    run_one("v01_f8", 8'h01, 8'hF8, 8'h0E | bit0, 8'h00);

    // Run A: 10-cycle req pulse, random messages
    load_src();
    low_writes = 0; ack_cnt = 0; first = -1;
    req = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 10) req = 1'b0;
      if (ack && first < 0) first = k;
    end
    check("runA_ack_cycle", first, 61);
    check("runA_ack_count", ack_cnt, 1);
    check("runA_low_writes", low_writes, 0);
    check_outputs("runA_cw", 15);

    // Abort with reset in cycle 20
    load_src();
    ack_cnt = 0;
    req = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      req = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_addr", addr, 0);
    check("abort_wr_en", wr_en, 0);
    for (int j = 0; j < 10; j++) snap[j] = mem[30 + j];
    check_outputs("abort_done_cw", 4);
    repeat (70) step();
    diffs = 0;
    for (int j = 0; j < 10; j++) if (mem[30 + j] !== snap[j]) diffs++;
    check("abort_bytes_kept", diffs, 0);
    check("abort_no_ack", ack_cnt, 0);

    // Run B: restart from message 0, req toggled mid-run, held high through DONE
    load_src();
    ack_cnt = 0; low_writes = 0; first = -1; second = -1;
    req = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (k < 55) req = 1'($urandom_range(0, 1));
      else if (k <= 63) req = 1'b1;
      else req = 1'b0;
      if (ack) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("runB_ack_cycle", first, 61);
    check("runB_second_ack", second, 123);
    check("runB_ack_count", ack_cnt, 2);
    check("runB_low_writes", low_writes, 0);
    check_outputs("runB_cw", 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
